// File: rtl/tx_source_arbiter_pkg.sv
// Shared types for the two-source UART transmit arbiter: FSM encoding and source IDs.
package tx_source_arbiter_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arbState_e;

    typedef logic srcId_t;

    localparam srcId_t SRC_BTN = 1'b0;
    localparam srcId_t SRC_RX  = 1'b1;

endpackage

// File: rtl/tx_source_arbiter_byte_fifo.sv
// Small first-word-fall-through byte FIFO; a push into a full FIFO lands only when the
// same cycle also pops.
module byte_fifo
    import tx_source_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic              doRead;
    logic              doWrite;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doRead  = pop && !empty;
    assign doWrite = push && (!full || doRead);
    assign dout    = mem[rdPtr[AW-1:0]];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + (AW+1)'(1);
            if (doRead)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tx_source_arbiter.sv
// Arbitrates the button and rx-echo byte streams onto one UART transmitter.
// Build option BTN_PRIORITY_EN: button always wins; otherwise round-robin.
module tx_source_arbiter
    import tx_source_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_rdy,
    input  logic [DATA_W-1:0] btn_data,
    input  logic              rx_rdy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_src,
    output logic              active,
    output logic              btn_ovf,
    output logic              rx_ovf
);

    arbState_e         state;
    arbState_e         nextState;
    logic              grant;
    srcId_t            grantSrc;
    logic              popBtn;
    logic              popRx;
    logic [DATA_W-1:0] btnDout;
    logic [DATA_W-1:0] rxDout;
    logic              btnEmpty;
    logic              btnFull;
    logic              rxEmpty;
    logic              rxFull;
    logic              txStart;
    logic [DATA_W-1:0] txData;
    srcId_t            txSrc;
    logic              activeQ;
    logic              btnOvf;
    logic              rxOvf;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) uBtnFifo (
        .clk   (clk),
        .reset (reset),
        .push  (btn_rdy),
        .din   (btn_data),
        .pop   (popBtn),
        .dout  (btnDout),
        .empty (btnEmpty),
        .full  (btnFull)
    );

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) uRxFifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_rdy),
        .din   (rx_data),
        .pop   (popRx),
        .dout  (rxDout),
        .empty (rxEmpty),
        .full  (rxFull)
    );

`ifndef BTN_PRIORITY_EN
    srcId_t lastGrant;

    // Starts as rx so the first contention favours the button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant <= SRC_RX;
        end else if (grant) begin
            lastGrant <= grantSrc;
        end
    end
`endif

    always_comb begin
        nextState = state;
        grant     = 1'b0;
        grantSrc  = SRC_BTN;
        popBtn    = 1'b0;
        popRx     = 1'b0;
        case (state)
            IDLE: begin
                if (!btnEmpty || !rxEmpty) begin
                    grant = 1'b1;
`ifdef BTN_PRIORITY_EN
                    grantSrc = btnEmpty ? SRC_RX : SRC_BTN;
`else
                    if (!btnEmpty && !rxEmpty) grantSrc = ~lastGrant;
                    else                       grantSrc = btnEmpty ? SRC_RX : SRC_BTN;
`endif
                    popBtn    = (grantSrc == SRC_BTN);
                    popRx     = (grantSrc == SRC_RX);
                    nextState = START;
                end
            end
            START:   nextState = WAIT_HI;
            WAIT_HI: if (tx_busy)  nextState = WAIT_LO;
            WAIT_LO: if (!tx_busy) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State plus registered transmitter-facing outputs; tx_data only moves on a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            txStart <= 1'b0;
            txData  <= '0;
            txSrc   <= SRC_BTN;
            activeQ <= 1'b0;
            btnOvf  <= 1'b0;
            rxOvf   <= 1'b0;
        end else begin
            state   <= nextState;
            txStart <= grant;
            activeQ <= (nextState != IDLE);
            if (grant) begin
                txData <= (grantSrc == SRC_RX) ? rxDout : btnDout;
                txSrc  <= grantSrc;
            end
            btnOvf <= btnOvf | (btn_rdy & btnFull & ~popBtn);
            rxOvf  <= rxOvf  | (rx_rdy  & rxFull  & ~popRx);
        end
    end

    assign tx_start = txStart;
    assign tx_data  = txData;
    assign tx_src   = txSrc;
    assign active   = activeQ;
    assign btn_ovf  = btnOvf;
    assign rx_ovf   = rxOvf;

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Directed self-checking bench for tx_source_arbiter with a simple busy-driving transmitter model.
module tb_tx_source_arbiter;

    localparam int FRAME = 20;

    logic       clk;
    logic       reset;
    logic       btn_rdy;
    logic [7:0] btn_data;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_src;
    logic       active;
    logic       btn_ovf;
    logic       rx_ovf;

    logic       holdBusy;
    int         txCnt;
    int         cyc;
    int         checks;
    int         failures;
    logic [7:0] txQ[$];
    logic       srcQ[$];
    int         cycQ[$];

    tx_source_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_rdy  (btn_rdy),
        .btn_data (btn_data),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_src   (tx_src),
        .active   (active),
        .btn_ovf  (btn_ovf),
        .rx_ovf   (rx_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Transmitter model: busy for FRAME cycles starting with the tx_start cycle.
    initial begin
        txCnt   = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset)        txCnt = 0;
            else if (tx_start) txCnt = FRAME;
            else if (txCnt != 0) txCnt--;
            tx_busy = holdBusy || (txCnt != 0);
        end
    end

    // Record every start pulse with its byte, source and cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                txQ.push_back(tx_data);
                srcQ.push_back(tx_src);
                cycQ.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b0;
        btn_rdy  = 1'b0;
        rx_rdy   = 1'b0;
        holdBusy = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        txQ.delete();
        srcQ.delete();
        cycQ.delete();
        @(negedge clk);
    endtask

    task automatic push_btn(input logic [7:0] d);
        btn_rdy  = 1'b1;
        btn_data = d;
        @(negedge clk);
        btn_rdy  = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] d);
        rx_rdy  = 1'b1;
        rx_data = d;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string name);
        int budget = 400;
        while (txQ.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (txQ.size() < n) begin
            failures++;
            $display("FAIL %s timeout: got %0d starts, expected %0d", name, txQ.size(), n);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        btn_rdy  = 1'b0;
        rx_rdy   = 1'b0;
        btn_data = 8'h00;
        rx_data  = 8'h00;
        holdBusy = 1'b0;
        #1;
        checks += 6;
        if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        if (tx_src !== 1'b0)   begin failures++; $display("FAIL rst_tx_src: got %b expected 0", tx_src); end
        if (active !== 1'b0)   begin failures++; $display("FAIL rst_active: got %b expected 0", active); end
        if (btn_ovf !== 1'b0)  begin failures++; $display("FAIL rst_btn_ovf: got %b expected 0", btn_ovf); end
        if (rx_ovf !== 1'b0)   begin failures++; $display("FAIL rst_rx_ovf: got %b expected 0", rx_ovf); end
        do_reset();
    endtask

    task automatic test_single_byte();
        int pushCyc;
        int budget;
        do_reset();
        repeat (5) @(negedge clk);
        pushCyc = cyc;
        push_btn(8'hA5);
        wait_tx(1, "single");
        checks += 3;
        if (cycQ[0] !== pushCyc + 2) begin failures++; $display("FAIL single_latency: got cycle %0d expected %0d", cycQ[0], pushCyc + 2); end
        if (txQ[0] !== 8'hA5)        begin failures++; $display("FAIL single_data: got %h expected a5", txQ[0]); end
        if (srcQ[0] !== 1'b0)        begin failures++; $display("FAIL single_src: got %b expected 0", srcQ[0]); end
        budget = 100;
        while (tx_busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (active !== 1'b1) begin failures++; $display("FAIL single_active_busy_fall: got %b expected 1", active); end
        @(negedge clk);
        checks += 2;
        if (active !== 1'b0)  begin failures++; $display("FAIL single_active_idle: got %b expected 0", active); end
        if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_held: got %h expected a5", tx_data); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] expD [5];
        logic       expS [5];
        do_reset();
        btn_rdy = 1'b1; btn_data = 8'h11;
        rx_rdy  = 1'b1; rx_data  = 8'h22;
        @(negedge clk);
        btn_rdy = 1'b0; rx_rdy = 1'b0;
        wait_tx(2, "simul_pair1");
        checks++;
        if (cycQ[1] - cycQ[0] !== FRAME + 2) begin
            failures++;
            $display("FAIL back_to_back_gap: got %0d expected %0d", cycQ[1] - cycQ[0], FRAME + 2);
        end
        push_btn(8'h55);
        wait_tx(3, "simul_single");
        btn_rdy = 1'b1; btn_data = 8'h33;
        rx_rdy  = 1'b1; rx_data  = 8'h44;
        @(negedge clk);
        btn_rdy = 1'b0; rx_rdy = 1'b0;
        wait_tx(5, "simul_pair2");
`ifdef BTN_PRIORITY_EN
        expD = '{8'h11, 8'h22, 8'h55, 8'h33, 8'h44};
        expS = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        expD = '{8'h11, 8'h22, 8'h55, 8'h44, 8'h33};
        expS = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (txQ[i] !== expD[i]) begin failures++; $display("FAIL simul_data[%0d]: got %h expected %h", i, txQ[i], expD[i]); end
            if (srcQ[i] !== expS[i]) begin failures++; $display("FAIL simul_src[%0d]: got %b expected %b", i, srcQ[i], expS[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] expD [5];
        do_reset();
        holdBusy = 1'b1;
        push_rx(8'h99);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= 5; i++) push_btn(8'(i));
        repeat (3) @(negedge clk);
        checks += 2;
        if (btn_ovf !== 1'b1) begin failures++; $display("FAIL ovf_btn_set: got %b expected 1", btn_ovf); end
        if (rx_ovf !== 1'b0)  begin failures++; $display("FAIL ovf_rx_clear: got %b expected 0", rx_ovf); end
        holdBusy = 1'b0;
        wait_tx(5, "ovf_drain");
        repeat (80) @(negedge clk);
        expD = '{8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
        checks += 2;
        if (txQ.size() !== 5) begin failures++; $display("FAIL ovf_count: got %0d expected 5", txQ.size()); end
        if (btn_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", btn_ovf); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (txQ[i] !== expD[i]) begin failures++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, txQ[i], expD[i]); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] expD [6];
        int budget;
        do_reset();
        holdBusy = 1'b1;
        push_rx(8'h77);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) push_btn(8'hA1 + 8'(i));
        repeat (25) @(negedge clk);
        checks++;
        if (btn_ovf !== 1'b0) begin failures++; $display("FAIL full_pre_ovf: got %b expected 0", btn_ovf); end
        holdBusy = 1'b0;
        budget = 50;
        while (active !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (active !== 1'b0) begin failures++; $display("FAIL full_reach_idle: got active %b expected 0", active); end
        push_btn(8'hE0);
        wait_tx(6, "full_drain");
        expD = '{8'h77, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hE0};
        checks++;
        if (btn_ovf !== 1'b0) begin failures++; $display("FAIL full_push_pop_ovf: got %b expected 0", btn_ovf); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (txQ[i] !== expD[i]) begin failures++; $display("FAIL full_data[%0d]: got %h expected %h", i, txQ[i], expD[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int nStarts;
        do_reset();
        holdBusy = 1'b1;
        push_rx(8'h55);
        repeat (4) @(negedge clk);
        push_btn(8'h66);
        push_rx(8'h67);
        repeat (3) @(negedge clk);
        checks += 2;
        if (active !== 1'b1)   begin failures++; $display("FAIL mid_pre_active: got %b expected 1", active); end
        if (tx_data !== 8'h55) begin failures++; $display("FAIL mid_pre_data: got %h expected 55", tx_data); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
        if (tx_src !== 1'b0)   begin failures++; $display("FAIL mid_tx_src: got %b expected 0", tx_src); end
        if (active !== 1'b0)   begin failures++; $display("FAIL mid_active: got %b expected 0", active); end
        @(negedge clk);
        reset    = 1'b1;
        holdBusy = 1'b0;
        nStarts  = txQ.size();
        repeat (60) @(negedge clk);
        checks += 2;
        if (txQ.size() !== nStarts) begin failures++; $display("FAIL mid_no_start: got %0d starts expected %0d", txQ.size(), nStarts); end
        if (active !== 1'b0)        begin failures++; $display("FAIL mid_idle_after: got %b expected 0", active); end
    endtask

    task automatic test_priority();
        logic [7:0] expD [5];
        do_reset();
        holdBusy = 1'b1;
        push_btn(8'hB0);
        repeat (4) @(negedge clk);
        push_rx(8'hC1);
        push_rx(8'hC2);
        push_rx(8'hC3);
        push_btn(8'hB1);
        repeat (2) @(negedge clk);
        holdBusy = 1'b0;
        wait_tx(5, "prio_drain");
`ifdef BTN_PRIORITY_EN
        expD = '{8'hB0, 8'hB1, 8'hC1, 8'hC2, 8'hC3};
`else
        expD = '{8'hB0, 8'hC1, 8'hB1, 8'hC2, 8'hC3};
`endif
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (txQ[i] !== expD[i]) begin failures++; $display("FAIL prio_data[%0d]: got %h expected %h", i, txQ[i], expD[i]); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_byte();
        test_simultaneous();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_source_arbiter.md
Name: tx_source_arbiter

Overview:
- Shares one UART transmitter between two byte producers: the button/switch entry path (one-cycle ready pulse plus byte) and the UART receive echo path (one-cycle ready pulse plus byte).
- Buffers each source in its own small FIFO and grants the transmitter round-robin.
- Drives the transmitter with a start-pulse/busy handshake.
- Sits between the input front-ends and the UART TX in the top level.

Parameters:
- DEPTH, 4, entries per source FIFO; power of two, minimum 2.
- AW, 2, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_rdy  input  1  one-cycle pulse; btn_data is valid in the same cycle.
- btn_data  input  8  button-path byte.
- rx_rdy  input  1  one-cycle pulse; rx_data is valid in the same cycle.
- rx_data  input  8  receive-path byte.
- tx_busy  input  1  high while the transmitter is shifting a frame.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  byte to transmit; held stable from tx_start until the frame completes.
- tx_src  output  1  source of the current byte: 0 = button, 1 = rx.
- active  output  1  high in every FSM state except IDLE.
- btn_ovf  output  1  sticky flag: a button byte was dropped.
- rx_ovf  output  1  sticky flag: an rx byte was dropped.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFOs emptied.
  - FSM goes to IDLE.
  - tx_start = 0, tx_data = 8'h00, tx_src = 0, active = 0, btn_ovf = 0, rx_ovf = 0.
  - last_grant = 1 (rx), so the first contention goes to the button.
- Push rules:
  - A ready pulse writes its byte into that source's FIFO at the same clock edge.
  - A push into a full FIFO is accepted only if the same FIFO is popped in that cycle.
  - Otherwise the byte is dropped, FIFO contents are unchanged, and the source's ovf flag sets.
  - ovf flags clear only on reset.
- Arbitration (evaluated in IDLE only):
  - If exactly one FIFO is non-empty, that source is granted.
  - If both are non-empty, the source != last_grant is granted.
  - Grant action: pop the winner, latch tx_data and tx_src, update last_grant, go to START.
- FSM states:
  - IDLE: wait for a non-empty FIFO, then grant as above.
  - START: tx_start = 1 for exactly one cycle, then go to WAIT_HI.
  - WAIT_HI: wait for tx_busy = 1, then go to WAIT_LO. If tx_busy is already 1 in the cycle after START, move on the next edge.
  - WAIT_LO: wait for tx_busy = 0, then go to IDLE.
- Latency: a ready pulse in cycle N into an empty system with an idle transmitter gives tx_start high in cycle N+2.
- Back-to-back bytes: the minimum gap between successive tx_start pulses is frame duration + 2 cycles.
- FIFO arithmetic:
  - Read and write pointers are AW+1 bits and wrap naturally.
  - empty = pointers equal; full = MSBs differ and low AW bits equal.
- Simultaneous btn_rdy and rx_rdy: both are pushed independently; no interaction between the two FIFOs.
- Reset mid-frame: tx_start and tx_data clear immediately. Any frame already in progress in the transmitter is that block's concern. Buffered bytes are lost.

Optional Feature:
- Macro name: BTN_PRIORITY_EN.
- Defined: fixed priority. The button FIFO always wins when non-empty, and last_grant is unused.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - the FSM state encoding: IDLE = 2'd0, START = 2'd1, WAIT_HI = 2'd2, WAIT_LO = 2'd3;
  - the source IDs: SRC_BTN = 1'b0, SRC_RX = 1'b1.
- One sub-module, byte_fifo, instantiated twice:
  - parameters DEPTH and AW;
  - ports clk, reset, push, din, pop, dout, empty, full;
  - dout is first-word fall-through (the head entry is visible without a pop).

Test Plan:
- Single byte: after reset, btn_rdy with btn_data = 8'hA5 in cycle 10 -> tx_start in cycle 12, tx_data = 8'hA5, tx_src = 0; model busy for 20 cycles -> active returns to 0 one cycle after busy falls.
- Simultaneous request: btn_rdy (8'h11) and rx_rdy (8'h22) in the same cycle -> transmit order 8'h11 then 8'h22. A second simultaneous pair (8'h33, 8'h44) -> order 8'h44 then 8'h33, because rx was not last granted.
- Overflow: hold tx_busy = 1 and push 5 button bytes 8'h01..8'h05 with DEPTH = 4 -> btn_ovf = 1, rx_ovf = 0, bytes 8'h01..8'h04 transmitted in order, 8'h05 never sent.
- Full FIFO with push and pop together: FIFO full, FSM in IDLE, btn_rdy pulses in the grant cycle -> new byte accepted, btn_ovf stays 0.
- Reset mid-operation: assert reset (drive to 0) during WAIT_LO with 2 bytes queued -> all outputs return to reset values asynchronously, and no tx_start occurs after release.
- BTN_PRIORITY_EN build: rx FIFO holding 3 bytes, button pushes 1 byte before the next grant -> the button byte is sent next.
